// File: rtl/sha1_padder.sv
// rtl/sha1_padder.sv - SHA-1 message padder producing 512-bit blocks
//
// Purpose: takes a big-endian 32-bit word stream. It appends the SHA-1
// padding: a 0x80 marker, zero fill and the 64-bit big-endian bit length.
// It then hands out complete 512-bit blocks on a valid/ready handshake.
//
// Ports:
//   clk, reset_n           clock, asynchronous active-low reset
//   in_valid/in_ready      input word handshake
//   in_data                message word, first byte in [31:24]
//   in_last, in_nbytes     final word flag and its valid byte count (0..4)
//   blk_valid/blk_ready    output block handshake
//   blk_data               block, word 0 in [511:480]
//   blk_first, blk_last    first block of message (load IV) / final block
module sha1_padder #(
   parameter int LEN_W = 32
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [31:0]  in_data,
   input  logic         in_last,
   input  logic [2:0]   in_nbytes,
   output logic         blk_valid,
   input  logic         blk_ready,
   output logic [511:0] blk_data,
   output logic         blk_first,
   output logic         blk_last
);

   typedef enum logic [1:0] {FILL, PAD, EMIT} state_t;

   state_t             state, state_nxt;
   logic [31:0]        blk_buf [16];
   logic [3:0]         widx;
   logic [LEN_W-1:0]   len_bytes;
   logic               pend80;    // marker still owed to the next word
   logic               msg_done;  // last input word seen, padding in progress
   logic               no_len;    // marker landed at word 14: length goes in the next block
   logic [2:0]         nb;
   logic [31:0]        in_word;
   logic [31:0]        pad_word;
   logic [63:0]        len_bits;

   assign len_bits = {{(61-LEN_W){1'b0}}, len_bytes, 3'b000};

   // Byte count of the current word: in_nbytes only matters on the last word.
   assign nb = (in_last && in_nbytes < 3'd4) ? in_nbytes : 3'd4;

   // Short final word: byte nb becomes the marker, later bytes become zero.
   always_comb begin
      in_word = in_data;
      for (int i = 0; i < 4; i++) begin
         if (i > int'(nb))
            in_word[31-8*i -: 8] = 8'h00;
         else if (i == int'(nb))
            in_word[31-8*i -: 8] = 8'h80;
      end
   end

   always_comb begin
      pad_word = 32'h0;
      if (pend80)
         pad_word = 32'h8000_0000;
      else if (!no_len && widx == 4'd14)
         pad_word = len_bits[63:32];
      else if (!no_len && widx == 4'd15)
         pad_word = len_bits[31:0];
   end

   always_comb begin
      blk_data = '0;
      for (int i = 0; i < 16; i++)
         blk_data[511-32*i -: 32] = blk_buf[i];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         state <= FILL;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      blk_valid = 1'b0;
      case (state)
         FILL: begin
            in_ready = 1'b1;
            if (in_valid) begin
               if (widx == 4'd15)
                  state_nxt = EMIT;
               else if (in_last)
                  state_nxt = PAD;
            end
         end
         PAD: begin
            if (widx == 4'd15)
               state_nxt = EMIT;
         end
         EMIT: begin
            blk_valid = 1'b1;
            if (blk_ready)
               state_nxt = (blk_last || !msg_done) ? FILL : PAD;
         end
         default: state_nxt = FILL;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 16; i++)
            blk_buf[i] <= 32'h0;
         widx      <= 4'd0;
         len_bytes <= '0;
         pend80    <= 1'b0;
         msg_done  <= 1'b0;
         no_len    <= 1'b0;
         blk_first <= 1'b1;
         blk_last  <= 1'b0;
      end else begin
         case (state)
            FILL: begin
               if (in_valid) begin
                  blk_buf[widx] <= in_word;
                  widx          <= widx + 4'd1;
                  len_bytes     <= len_bytes + LEN_W'(nb);
                  if (in_last) begin
                     msg_done <= 1'b1;
                     pend80   <= (nb == 3'd4);
                     no_len   <= (nb != 3'd4) && (widx == 4'd14);
                  end
               end
            end
            PAD: begin
               blk_buf[widx] <= pad_word;
               widx          <= widx + 4'd1;
               if (pend80) begin
                  pend80 <= 1'b0;
                  if (widx == 4'd14)
                     no_len <= 1'b1;
               end
               // Length only fits if no marker was placed at 14/15 in this block.
               if (widx == 4'd15)
                  blk_last <= !pend80 && !no_len;
            end
            EMIT: begin
               if (blk_ready) begin
                  widx   <= 4'd0;
                  no_len <= 1'b0;
                  if (blk_last) begin
                     blk_last  <= 1'b0;
                     blk_first <= 1'b1;
                     len_bytes <= '0;
                     msg_done  <= 1'b0;
                  end else begin
                     blk_first <= 1'b0;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sha1_padder.sv
// tb/tb_sha1_padder.sv - self-checking bench for sha1_padder
module tb_sha1_padder;

   logic         clk = 1'b0;
   logic         reset_n;
   logic         in_valid;
   logic         in_ready;
   logic [31:0]  in_data;
   logic         in_last;
   logic [2:0]   in_nbytes;
   logic         blk_valid;
   logic         blk_ready;
   logic [511:0] blk_data;
   logic         blk_first;
   logic         blk_last;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   sha1_padder #(.LEN_W(32)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .in_nbytes (in_nbytes),
      .blk_valid (blk_valid),
      .blk_ready (blk_ready),
      .blk_data  (blk_data),
      .blk_first (blk_first),
      .blk_last  (blk_last)
   );

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      in_valid  = 1'b0;
      in_data   = 32'h0;
      in_last   = 1'b0;
      in_nbytes = 3'd0;
      blk_ready = 1'b0;
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_in_ready"},  in_ready,  1'b1);
      chk({tag, "_blk_valid"}, blk_valid, 1'b0);
      chk({tag, "_blk_first"}, blk_first, 1'b1);
      chk({tag, "_blk_last"},  blk_last,  1'b0);
      chk({tag, "_blk_data"},  blk_data,  512'h0);
   endtask

   // Single-word message against a constant expected block; optional hold
   // of blk_ready low to exercise backpressure.
   task automatic run_single(input string tag, input logic [31:0] word, input logic [2:0] nbytes,
                             input logic [511:0] exp_blk, input int hold, input int exp_lat);
      int n;
      @(negedge clk);
      chk({tag, "_accept_ready"}, in_ready, 1'b1);
      in_valid = 1'b1; in_data = word; in_last = 1'b1; in_nbytes = nbytes; blk_ready = 1'b0;
      @(negedge clk);
      idle();
      n = 1;
      chk({tag, "_pad_in_ready"}, in_ready, 1'b0);
      while (!blk_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (exp_lat > 0) chk({tag, "_latency"}, n, exp_lat);
      chk({tag, "_valid"}, blk_valid, 1'b1);
      chk({tag, "_data"},  blk_data,  exp_blk);
      chk({tag, "_first"}, blk_first, 1'b1);
      chk({tag, "_last"},  blk_last,  1'b1);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk($sformatf("%s_hold%0d_data", tag, i),     blk_data,  exp_blk);
         chk($sformatf("%s_hold%0d_valid", tag, i),    blk_valid, 1'b1);
         chk($sformatf("%s_hold%0d_flags", tag, i),    {blk_first, blk_last}, 2'b11);
         chk($sformatf("%s_hold%0d_in_ready", tag, i), in_ready,  1'b0);
      end
      blk_ready = 1'b1;
      @(negedge clk);
      blk_ready = 1'b1;
      chk({tag, "_one_handshake"}, blk_valid, 1'b0);
      chk({tag, "_first_rearmed"}, blk_first, 1'b1);
      idle();
   endtask

   // Random-content message checked against a byte-level padding model.
   task automatic run_msg(input int len, input int vpct, input int rpct);
      logic [7:0]   msg[$];
      logic [7:0]   pb[$];
      logic [511:0] exp_q[$];
      logic [511:0] blk;
      logic [63:0]  bitlen;
      int nblk, nwords, wi, bi, cyc, idx;
      for (int i = 0; i < len; i++) msg.push_back(8'($urandom));
      pb = msg;
      pb.push_back(8'h80);
      while (pb.size() % 64 != 56) pb.push_back(8'h00);
      bitlen = 64'(len) * 64'd8;
      for (int i = 7; i >= 0; i--) pb.push_back(bitlen[8*i +: 8]);
      nblk = pb.size() / 64;
      for (int k = 0; k < nblk; k++) begin
         blk = '0;
         for (int j = 0; j < 64; j++) blk = {blk[503:0], pb[64*k+j]};
         exp_q.push_back(blk);
      end
      nwords = (len == 0) ? 1 : (len + 3) / 4;
      wi = 0; bi = 0; cyc = 0;
      while (bi < nblk && cyc < 5000) begin
         @(negedge clk);
         if (wi < nwords && $urandom_range(99) < vpct) begin
            in_valid = 1'b1;
            for (int b = 0; b < 4; b++) begin
               idx = 4*wi + b;
               in_data[31-8*b -: 8] = (idx < len) ? msg[idx] : 8'($urandom);
            end
            in_last   = (wi == nwords - 1);
            in_nbytes = in_last ? 3'(len - 4*wi) : 3'($urandom_range(1, 4));
         end else begin
            in_valid  = 1'b0;
            in_data   = $urandom;
            in_last   = 1'($urandom);
            in_nbytes = 3'($urandom_range(0, 4));
         end
         blk_ready = ($urandom_range(99) < rpct);
         if (in_valid && in_ready) wi++;
         if (blk_valid && blk_ready) begin
            chk($sformatf("len%0d_blk%0d_data", len, bi),  blk_data,  exp_q[bi]);
            chk($sformatf("len%0d_blk%0d_first", len, bi), blk_first, (bi == 0));
            chk($sformatf("len%0d_blk%0d_last", len, bi),  blk_last,  (bi == nblk - 1));
            bi++;
         end
         cyc++;
      end
      chk($sformatf("len%0d_blocks", len), bi, nblk);
      chk($sformatf("len%0d_words", len),  wi, nwords);
      @(negedge clk);
      idle();
   endtask

   initial begin
      int lens[18] = '{56, 64, 3, 0, 52, 53, 54, 55, 57, 58, 59, 60, 61, 62, 63, 119, 120, 128};
      reset_n = 1'b0;
      idle();
      @(negedge clk);
      @(negedge clk);
      check_reset_vals("reset");
      reset_n = 1'b1;

      run_single("abc", 32'h6162_6300, 3'd3, {32'h6162_6380, 448'h0, 32'h0000_0018}, 5, 16);
      run_single("empty", 32'h1234_5678, 3'd0, {32'h8000_0000, 480'h0}, 0, 0);

      for (int i = 0; i < 18; i++)
         run_msg(lens[i], (i < 4) ? 100 : 70, (i < 4) ? 100 : 60);
      for (int i = 0; i < 12; i++)
         run_msg($urandom_range(0, 200), $urandom_range(30, 100), $urandom_range(20, 100));

      // Reset mid-message: seven words in, then abort.
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         in_valid = 1'b1; in_data = $urandom; in_last = 1'b0; in_nbytes = 3'd4;
      end
      @(negedge clk);
      idle();
      reset_n = 1'b0;
      #1;
      check_reset_vals("midreset");
      @(negedge clk);
      reset_n = 1'b1;
      run_single("abc_after_reset", 32'h6162_6300, 3'd3, {32'h6162_6380, 448'h0, 32'h0000_0018}, 0, 16);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
